// File: rtl/daisi_adc_pkg.sv
// rtl/daisi_adc_pkg.sv - shared state encoding, frame constants and helpers for the ADC acquisition path
package daisi_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADC_RST   = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CONVERT   = 3'd3,
    ST_WAIT_DRDY = 3'd4,
    ST_CAPTURE   = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAULT     = 3'd7
  } adc_state_t;

  // channel words that make up one complete frame
  localparam int WORDS_PER_FRAME = 8;

  // shortest CONVST-to-CONVST spacing the sequencer will honour
  localparam int MIN_SAMPLE_PERIOD = 16;

  // configured period with the floor applied
  function automatic logic [23:0] clamp_period(input logic [23:0] period);
    if (period < 24'(MIN_SAMPLE_PERIOD)) begin
      return 24'(MIN_SAMPLE_PERIOD);
    end
    return period;
  endfunction

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/adc_drdy_sync.sv
// rtl/adc_drdy_sync.sv - two-flop synchroniser with rising-edge detect for async ADC status lines
module adc_drdy_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // two flops for metastability, a third holds last cycle's level for the edge detect
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/adc_acquisition_controller.sv
// rtl/adc_acquisition_controller.sv - acquisition sequencer for the 8-channel serial ADC
module adc_acquisition_controller
  import daisi_adc_pkg::*;
#(
  parameter int ADC_RESET_CYCLES = 64,
  parameter int SETTLE_CYCLES    = 4096,
  parameter int CONVST_WIDTH     = 4,
  parameter int DRDY_TIMEOUT     = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic [23:0] cfg_sample_period,
  input  logic [15:0] cfg_frame_count,
  output logic        adc_reset_n,
  output logic        adc_convst,
  input  logic        adc_data_ready,
  output logic        capture_enable,
  input  logic        word_written,
  input  logic        buffer_full,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] frames_captured,
  output logic [15:0] frames_dropped
);

  localparam int CNT_MAX_A = (DRDY_TIMEOUT > SETTLE_CYCLES) ? DRDY_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > ADC_RESET_CYCLES) ? CNT_MAX_A : ADC_RESET_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int WCNT_W    = $clog2(WORDS_PER_FRAME + 1);

  adc_state_t        state_q;
  adc_state_t        state_d;
  logic [CNT_W-1:0]  cyc_q;
  logic [23:0]       period_q;
  logic [23:0]       ptmr_q;
  logic [15:0]       target_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              frame_resolved_q;
  logic              capture_enable_q;
  logic              done_q;
  logic [15:0]       captured_q;
  logic [15:0]       dropped_q;

  logic              drdy_rise;
  logic              start_run;
  logic              cap_inc;
  logic              drop_inc;
  logic              last_word;
  logic              period_end;
  logic              clr_cyc;
  logic [16:0]       frames_total;

  adc_drdy_sync u_drdy_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (adc_data_ready),
    .rise     (drdy_rise)
  );

  // the word that completes a frame, only while the frame is still open
  assign last_word  = word_written && !frame_resolved_q &&
                      (wcnt_q == WCNT_W'(WORDS_PER_FRAME - 1));
  assign period_end = (ptmr_q == 24'd0);

  // the timeout measures from CONVST rise, so the count carries across CONVERT -> WAIT_DRDY
  assign clr_cyc = (state_d != state_q) &&
                   !((state_q == ST_CONVERT) && (state_d == ST_WAIT_DRDY));

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and per-cycle frame accounting decisions; cmd_stop overrides everything
  always_comb begin
    state_d      = state_q;
    start_run    = 1'b0;
    cap_inc      = 1'b0;
    drop_inc     = 1'b0;
    frames_total = 17'd0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (cmd_start) begin
          state_d   = ST_ADC_RST;
          start_run = 1'b1;
        end
      end
      ST_ADC_RST: begin
        if (cyc_q == CNT_W'(ADC_RESET_CYCLES - 1)) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cyc_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (cyc_q == CNT_W'(CONVST_WIDTH - 1)) state_d = ST_WAIT_DRDY;
      end
      ST_WAIT_DRDY: begin
        if (drdy_rise) begin
          state_d  = ST_CAPTURE;
          drop_inc = buffer_full;
        end else if (cyc_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
        end
      end
      ST_CAPTURE: begin
        cap_inc = last_word;
        if (period_end) begin
          drop_inc     = !frame_resolved_q && !last_word;
          frames_total = {1'b0, captured_q} + {1'b0, dropped_q} +
                         {16'd0, cap_inc} + {16'd0, drop_inc};
          if ((target_q != 16'd0) && (frames_total == {1'b0, target_q})) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CONVERT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmd_stop) begin
      state_d   = ST_IDLE;
      start_run = 1'b0;
      cap_inc   = 1'b0;
      drop_inc  = 1'b0;
    end
  end

  // timers, per-frame word tracking, run configuration and the frame counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q            <= '0;
      period_q         <= 24'(MIN_SAMPLE_PERIOD);
      ptmr_q           <= 24'd0;
      target_q         <= 16'd0;
      wcnt_q           <= '0;
      frame_resolved_q <= 1'b0;
      capture_enable_q <= 1'b0;
      done_q           <= 1'b0;
      captured_q       <= 16'd0;
      dropped_q        <= 16'd0;
    end else begin
      if (clr_cyc) begin
        cyc_q <= '0;
      end else if (busy) begin
        cyc_q <= cyc_q + 1'b1;
      end

      if ((state_d == ST_CONVERT) && (state_q != ST_CONVERT)) begin
        ptmr_q <= period_q - 24'd1;
      end else if (!period_end) begin
        ptmr_q <= ptmr_q - 24'd1;
      end

      if ((state_q == ST_WAIT_DRDY) && (state_d == ST_CAPTURE)) begin
        wcnt_q           <= '0;
        frame_resolved_q <= buffer_full;
      end else if (state_q == ST_CAPTURE) begin
        if (word_written && !frame_resolved_q) wcnt_q <= wcnt_q + 1'b1;
        if (cap_inc || drop_inc) frame_resolved_q <= 1'b1;
      end

      if (start_run) begin
        period_q   <= clamp_period(cfg_sample_period);
        target_q   <= cfg_frame_count;
        captured_q <= 16'd0;
        dropped_q  <= 16'd0;
      end else begin
        if (cap_inc)  captured_q <= sat_inc16(captured_q);
        if (drop_inc) dropped_q  <= sat_inc16(dropped_q);
      end

      capture_enable_q <= (state_q == ST_CONVERT) || (state_q == ST_WAIT_DRDY) ||
                          (state_q == ST_CAPTURE);
      done_q           <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  // strobes follow the state directly so cmd_stop can pull them inactive in the same cycle
  assign adc_convst      = (state_q == ST_CONVERT) && !cmd_stop;
  assign adc_reset_n     = !((state_q == ST_ADC_RST) && !cmd_stop);
  assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_FAULT);
  assign fault           = (state_q == ST_FAULT);
  assign done            = done_q;
  assign capture_enable  = capture_enable_q;
  assign frames_captured = captured_q;
  assign frames_dropped  = dropped_q;

endmodule

// File: tb/tb_adc_acquisition_controller.sv
// tb/tb_adc_acquisition_controller.sv - randomized self-checking bench for adc_acquisition_controller
module tb_adc_acquisition_controller;

  localparam int T_RST    = 64;
  localparam int T_SETTLE = 512;
  localparam int T_CW     = 4;
  localparam int T_TO     = 6000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_start, cmd_stop;
  logic [23:0] cfg_sample_period;
  logic [15:0] cfg_frame_count;
  logic        adc_reset_n, adc_convst, adc_data_ready, capture_enable;
  logic        word_written, buffer_full, busy, done, fault;
  logic [15:0] frames_captured, frames_dropped;

  always #5 clock = ~clock;

  adc_acquisition_controller #(
    .ADC_RESET_CYCLES (T_RST),
    .SETTLE_CYCLES    (T_SETTLE),
    .CONVST_WIDTH     (T_CW),
    .DRDY_TIMEOUT     (T_TO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .cmd_start         (cmd_start),
    .cmd_stop          (cmd_stop),
    .cfg_sample_period (cfg_sample_period),
    .cfg_frame_count   (cfg_frame_count),
    .adc_reset_n       (adc_reset_n),
    .adc_convst        (adc_convst),
    .adc_data_ready    (adc_data_ready),
    .capture_enable    (capture_enable),
    .word_written      (word_written),
    .buffer_full       (buffer_full),
    .busy              (busy),
    .done              (done),
    .fault             (fault),
    .frames_captured   (frames_captured),
    .frames_dropped    (frames_dropped)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned rise_q[$];
  int          done_pulses = 0;
  int unsigned fault_cyc = 0;
  int unsigned rst_lo_cyc = 0;
  int unsigned rst_hi_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge adc_convst) rise_q.push_back(cyc);
  always @(negedge clock) if (done === 1'b1) done_pulses++;
  always @(posedge fault) fault_cyc = cyc;
  always @(negedge adc_reset_n) rst_lo_cyc = cyc;
  always @(posedge adc_reset_n) rst_hi_cyc = cyc;

  // ADC + serial-interface model: per frame plan, DRDY after a delay then N channel words
  bit model_respond = 0;
  int drdy_delay = 200;
  int word_gap = 2;
  int plan_words[16];
  bit plan_full[16];
  int frame_idx = 0;

  initial begin
    adc_data_ready = 1'b0;
    word_written   = 1'b0;
    buffer_full    = 1'b0;
    forever begin
      @(posedge adc_convst);
      if (model_respond) begin
        int idx;
        idx = frame_idx % 16;
        frame_idx++;
        repeat (drdy_delay) @(posedge clock);
        #1 adc_data_ready = 1'b1; buffer_full = plan_full[idx];
        repeat (4) @(posedge clock);
        #1 adc_data_ready = 1'b0; buffer_full = 1'b0;
        for (int w = 0; w < plan_words[idx]; w++) begin
          repeat (word_gap) @(posedge clock);
          #1 word_written = 1'b1;
          @(posedge clock);
          #1 word_written = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic plan_all(input int words);
    for (int i = 0; i < 16; i++) begin
      plan_words[i] = words;
      plan_full[i]  = 1'b0;
    end
  endtask

  task automatic pulse_start(input int period, input int frames);
    cfg_sample_period = 24'(period);
    cfg_frame_count   = 16'(frames);
    cmd_start = 1'b1;
    @(posedge clock);
    #1 cmd_start = 1'b0;
  endtask

  // starts a bounded run and returns once busy drops (or the budget runs out)
  task automatic do_run(input int period, input int frames);
    int budget;
    bit ok;
    budget = T_RST + T_SETTLE + ((period < 16) ? 16 : period) * frames + 500;
    rise_q.delete();
    done_pulses = 0;
    frame_idx   = 0;
    pulse_start(period, frames);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL run_timeout: busy still %0b after %0d cycles, required 0", busy, budget);
    end
    tick(3);
  endtask

  task automatic wait_rises(input int n, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      if (rise_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL convst_wait: saw %0d CONVST rises, required %0d", rise_q.size(), n);
    end
  endtask

  function automatic int bad_spacing(input int period);
    int bad;
    bad = 0;
    for (int i = 1; i < rise_q.size(); i++)
      if (int'(rise_q[i] - rise_q[i-1]) != period) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_cmp++; if (adc_reset_n !== 1'b1) begin n_bad++; $display("FAIL reset_adc_reset_n: got %0b required 1", adc_reset_n); end
    n_cmp++; if (adc_convst !== 1'b0) begin n_bad++; $display("FAIL reset_convst: got %0b required 0", adc_convst); end
    n_cmp++; if ({capture_enable, busy, done, fault} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b required 0000", {capture_enable, busy, done, fault}); end
    n_cmp++; if ({frames_captured, frames_dropped} !== 32'd0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d required 0/0", frames_captured, frames_dropped); end
    reset = 1'b0;
    tick(4);
    n_cmp++; if ({busy, adc_reset_n} !== 2'b01) begin n_bad++; $display("FAIL idle_after_reset: busy,reset_n got %b required 01", {busy, adc_reset_n}); end
  endtask

  task automatic test_basic_run();
    model_respond = 1; drdy_delay = 200; word_gap = 2; plan_all(8);
    do_run(1000, 3);
    n_cmp++; if (rise_q.size() !== 3) begin n_bad++; $display("FAIL basic_convst_count: got %0d required 3", rise_q.size()); end
    n_cmp++; if (bad_spacing(1000) !== 0) begin n_bad++; $display("FAIL basic_spacing: %0d gaps off, required 0", bad_spacing(1000)); end
    n_cmp++; if (frames_captured !== 16'd3 || frames_dropped !== 16'd0) begin n_bad++; $display("FAIL basic_counts: got %0d/%0d required 3/0", frames_captured, frames_dropped); end
    n_cmp++; if (done_pulses !== 1) begin n_bad++; $display("FAIL basic_done_pulse: got %0d cycles required 1", done_pulses); end
    n_cmp++; if ({busy, fault, capture_enable} !== 3'b000) begin n_bad++; $display("FAIL basic_idle_flags: got %b required 000", {busy, fault, capture_enable}); end
    n_cmp++; if (int'(rst_hi_cyc - rst_lo_cyc) !== T_RST) begin n_bad++; $display("FAIL adc_reset_width: got %0d required %0d", rst_hi_cyc - rst_lo_cyc, T_RST); end
    if (rise_q.size() > 0) begin
      n_cmp++; if (int'(rise_q[0] - rst_hi_cyc) !== T_SETTLE) begin n_bad++; $display("FAIL settle_time: got %0d required %0d", rise_q[0] - rst_hi_cyc, T_SETTLE); end
    end
  endtask

  task automatic test_fault();
    bit ok;
    model_respond = 0;
    rise_q.delete();
    pulse_start(1000, 1);
    ok = 0;
    for (int i = 0; i < T_RST + T_SETTLE + T_TO + 100; i++) begin
      @(negedge clock);
      if (fault === 1'b1) begin ok = 1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fault_timeout: fault got %0b required 1", fault); end
    if (ok && rise_q.size() > 0) begin
      n_cmp++; if (int'(fault_cyc - rise_q[0]) !== T_TO) begin n_bad++; $display("FAIL fault_latency: got %0d required %0d", fault_cyc - rise_q[0], T_TO); end
    end
    tick(2);
    n_cmp++; if ({fault, busy, capture_enable} !== 3'b100) begin n_bad++; $display("FAIL fault_flags: got %b required 100", {fault, busy, capture_enable}); end
    n_cmp++; if (rise_q.size() !== 1) begin n_bad++; $display("FAIL fault_convst_count: got %0d required 1", rise_q.size()); end
  endtask

  task automatic test_buffer_full();
    model_respond = 1; drdy_delay = 150; word_gap = 3; plan_all(8);
    plan_full[1] = 1'b1;
    do_run(600, 4);
    n_cmp++; if (frames_captured !== 16'd3 || frames_dropped !== 16'd1) begin n_bad++; $display("FAIL full_counts: got %0d/%0d required 3/1", frames_captured, frames_dropped); end
    n_cmp++; if (rise_q.size() !== 4 || done_pulses !== 1 || fault !== 1'b0) begin n_bad++; $display("FAIL full_done: rises %0d done %0d fault %0b required 4 1 0", rise_q.size(), done_pulses, fault); end
  endtask

  task automatic test_short_frame();
    model_respond = 1; drdy_delay = 100; word_gap = 4; plan_all(8);
    plan_words[0] = 5;
    do_run(700, 3);
    n_cmp++; if (frames_captured !== 16'd2 || frames_dropped !== 16'd1) begin n_bad++; $display("FAIL short_counts: got %0d/%0d required 2/1", frames_captured, frames_dropped); end
    n_cmp++; if (rise_q.size() !== 3 || bad_spacing(700) !== 0) begin n_bad++; $display("FAIL short_schedule: rises %0d bad gaps %0d required 3 0", rise_q.size(), bad_spacing(700)); end
  endtask

  task automatic test_random_runs();
    int period, frames, exp_cap, exp_drop;
    for (int it = 0; it < 3; it++) begin
      period = $urandom_range(400, 1200);
      frames = $urandom_range(2, 4);
      drdy_delay = $urandom_range(20, 200);
      word_gap = $urandom_range(1, 8);
      model_respond = 1;
      exp_cap = 0;
      for (int f = 0; f < 16; f++) begin
        plan_words[f] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 8;
        plan_full[f]  = ($urandom_range(0, 3) == 0);
      end
      for (int f = 0; f < frames; f++)
        if (!plan_full[f] && plan_words[f] >= 8) exp_cap++;
      exp_drop = frames - exp_cap;
      do_run(period, frames);
      n_cmp++; if (frames_captured !== 16'(exp_cap) || frames_dropped !== 16'(exp_drop)) begin n_bad++; $display("FAIL random_counts it%0d: got %0d/%0d required %0d/%0d", it, frames_captured, frames_dropped, exp_cap, exp_drop); end
      n_cmp++; if (rise_q.size() !== frames || bad_spacing(period) !== 0) begin n_bad++; $display("FAIL random_schedule it%0d: rises %0d bad gaps %0d required %0d 0", it, rise_q.size(), bad_spacing(period), frames); end
      n_cmp++; if (done_pulses !== 1) begin n_bad++; $display("FAIL random_done it%0d: got %0d required 1", it, done_pulses); end
    end
  endtask

  task automatic test_stop();
    model_respond = 1; drdy_delay = 200; word_gap = 3; plan_all(8);
    rise_q.delete(); frame_idx = 0;
    pulse_start(500, 0);
    wait_rises(2, T_RST + T_SETTLE + 1200);
    tick(20);
    cmd_stop = 1'b1;
    @(posedge clock);
    #1 cmd_stop = 1'b0;
    n_cmp++; if ({busy, adc_convst} !== 2'b00) begin n_bad++; $display("FAIL stop_idle: busy,convst got %b required 00", {busy, adc_convst}); end
    n_cmp++; if (frames_captured !== 16'd1 || frames_dropped !== 16'd0) begin n_bad++; $display("FAIL stop_counts: got %0d/%0d required 1/0", frames_captured, frames_dropped); end
    tick(300);
    n_cmp++; if (frames_captured !== 16'd1 || capture_enable !== 1'b0) begin n_bad++; $display("FAIL stop_hold: captured %0d cap_en %0b required 1 0", frames_captured, capture_enable); end
    model_respond = 0;
    pulse_start(500, 0);
    n_cmp++; if (frames_captured !== 16'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL restart_clear: captured %0d busy %0b required 0 1", frames_captured, busy); end
    tick(10);
    cmd_stop = 1'b1;
    #1;
    n_cmp++; if (adc_reset_n !== 1'b1) begin n_bad++; $display("FAIL stop_reset_n: got %0b required 1", adc_reset_n); end
    @(posedge clock);
    #1 cmd_stop = 1'b0;
    cmd_start = 1'b1; cmd_stop = 1'b1;
    @(posedge clock);
    #1 cmd_start = 1'b0; cmd_stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_stop_same: busy got %0b required 0", busy); end
    rise_q.delete();
    pulse_start(500, 0);
    wait_rises(1, T_RST + T_SETTLE + 50);
    cmd_stop = 1'b1;
    #1;
    n_cmp++; if (adc_convst !== 1'b0) begin n_bad++; $display("FAIL stop_convst: got %0b required 0", adc_convst); end
    @(posedge clock);
    #1 cmd_stop = 1'b0;
    tick(2);
  endtask

  task automatic test_min_period();
    model_respond = 1; drdy_delay = 5; plan_all(0);
    rise_q.delete(); frame_idx = 0;
    pulse_start(3, 0);
    wait_rises(5, T_RST + T_SETTLE + 200);
    n_cmp++; if (bad_spacing(16) !== 0) begin n_bad++; $display("FAIL min_period_spacing: %0d gaps off, required 0", bad_spacing(16)); end
    n_cmp++; if (frames_captured !== 16'd0 || frames_dropped !== 16'd4) begin n_bad++; $display("FAIL min_period_counts: got %0d/%0d required 0/4", frames_captured, frames_dropped); end
    tick(11);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({adc_reset_n, adc_convst, capture_enable, busy, done, fault} !== 6'b100000) begin n_bad++; $display("FAIL midrun_reset_flags: got %b required 100000", {adc_reset_n, adc_convst, capture_enable, busy, done, fault}); end
    n_cmp++; if ({frames_captured, frames_dropped} !== 32'd0) begin n_bad++; $display("FAIL midrun_reset_counters: got %0d/%0d required 0/0", frames_captured, frames_dropped); end
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b1;
    cmd_start = 1'b0;
    cmd_stop = 1'b0;
    cfg_sample_period = 24'd0;
    cfg_frame_count = 16'd0;
    plan_all(8);
    test_reset();
    test_basic_run();
    test_fault();
    test_buffer_full();
    test_short_frame();
    test_random_runs();
    test_stop();
    test_min_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
